// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter and its benches.
// Direction/mode encodings plus integer reference helpers.
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic {MODE_WRAP, MODE_SAT} cnt_mode_e;

   function automatic int wrap_add(input int cnt, input int s,
                                   input int mx, input logic up);
      int raw;
      raw = (up == DIR_UP) ? cnt + s : cnt - s;
      return (raw + mx + 1) % (mx + 1);
   endfunction

   function automatic int sat_add(input int cnt, input int s,
                                  input int mx, input logic up);
      int raw;
      raw = (up == DIR_UP) ? cnt + s : cnt - s;
      if (raw < 0)  return 0;
      if (raw > mx) return mx;
      return raw;
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enabled-cycle prescaler: tick on every PRESCALE-th cycle with en=1.
// Used by updown_counter_mod only when COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down modulo counter with step, load, wrap/saturate and event pulse.
// Optional enabled-cycle prescaler under `define COUNTER_PRESCALE_EN.
module updown_counter_mod
   import counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MAX      = 255,
   parameter int RST_VAL  = 0,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             sat,
   input  logic [WIDTH-1:0] step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             evt
);

   localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX);
   localparam logic [WIDTH:0]   MOD_W = MAX_W + 1'b1;
   localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] RST_N = WIDTH'(RST_VAL);

   if (PRESCALE < 1 || RST_VAL > MAX || MAX > 2**WIDTH - 1)
   begin : g_bad_param
      $error("updown_counter_mod: illegal parameters");
   end

   logic tick;

`ifdef COUNTER_PRESCALE_EN
   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clr   (load),
      .tick  (tick)
   );
`else
   assign tick = en;
`endif

   cnt_mode_e        mode;
   logic [WIDTH:0]   cur;
   logic [WIDTH:0]   s;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   dif;
   logic [WIDTH-1:0] count_d;
   logic             evt_d;

   assign mode = sat ? MODE_SAT : MODE_WRAP;

   // Step is clamped to MAX so a wrap never laps the range twice.
   always_comb begin
      cur     = {1'b0, count};
      s       = ({1'b0, step} > MAX_W) ? MAX_W : {1'b0, step};
      sum     = cur + s;
      dif     = '0;
      count_d = count;
      evt_d   = 1'b0;
      if (load) begin
         count_d = ({1'b0, load_val} > MAX_W) ? MAX_N : load_val;
      end else if (tick) begin
         if (up == DIR_UP) begin
            if (sum > MAX_W) begin
               evt_d = 1'b1;
               dif   = sum - MOD_W;
               count_d = (mode == MODE_SAT) ? MAX_N : dif[WIDTH-1:0];
            end else begin
               count_d = sum[WIDTH-1:0];
            end
         end else begin
            if (s > cur) begin
               evt_d = 1'b1;
               dif   = cur + MOD_W - s;
               count_d = (mode == MODE_SAT) ? '0 : dif[WIDTH-1:0];
            end else begin
               dif     = cur - s;
               count_d = dif[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= RST_N;
         evt   <= 1'b0;
      end else begin
         count <= count_d;
         evt   <= evt_d;
      end
   end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench for updown_counter_mod: directed literals plus
// randomized traffic checked every cycle against an integer model.
module tb_updown_counter_mod;

   localparam int WIDTH    = 8;
   localparam int MAX      = 9;
   localparam int RST_VAL  = 0;
   localparam int PRESCALE = 4;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             up;
   logic             sat;
   logic [WIDTH-1:0] step;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             evt;

   int tests = 0;
   int fails = 0;
   bit run   = 0;

   int m_cnt = RST_VAL;
   bit m_evt = 0;
   int m_pre = 0;

   updown_counter_mod #(
      .WIDTH    (WIDTH),
      .MAX      (MAX),
      .RST_VAL  (RST_VAL),
      .PRESCALE (PRESCALE)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .sat      (sat),
      .step     (step),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .evt      (evt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Reference model: plain integer arithmetic on the counter's rules.
   always @(posedge clk or negedge rst_n) begin
      int  s;
      int  raw;
      bit  adv;
      if (!rst_n) begin
         m_cnt = RST_VAL;
         m_evt = 0;
         m_pre = 0;
      end else begin
         m_evt = 0;
         adv   = en;
`ifdef COUNTER_PRESCALE_EN
         if (load) begin
            m_pre = 0;
         end else if (en) begin
            m_pre = (m_pre + 1) % PRESCALE;
            adv   = (m_pre == 0);
         end
`endif
         if (load) begin
            m_cnt = (int'(load_val) > MAX) ? MAX : int'(load_val);
         end else if (adv) begin
            s   = (int'(step) > MAX) ? MAX : int'(step);
            raw = up ? m_cnt + s : m_cnt - s;
            if (raw < 0 || raw > MAX) begin
               m_evt = 1;
               if (sat) m_cnt = (raw < 0) ? 0 : MAX;
               else     m_cnt = (raw + MAX + 1) % (MAX + 1);
            end else begin
               m_cnt = raw;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (run && rst_n === 1'b1) begin
         chk("model_count", {24'b0, count}, m_cnt);
         chk("model_evt", {31'b0, evt}, int'(m_evt));
      end
   end

   task automatic cyc(input bit e, input bit u, input bit sa,
                      input int st, input bit ld, input int lv);
      en       = e;
      up       = u;
      sat      = sa;
      step     = WIDTH'(st);
      load     = ld;
      load_val = WIDTH'(lv);
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string nm, input int c, input int e);
      chk({nm, "_count"}, {24'b0, count}, c);
      chk({nm, "_evt"}, {31'b0, evt}, e);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      lit("async_rst", RST_VAL, 0);
      #4 rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      en       = 1'b0;
      up       = 1'b1;
      sat      = 1'b0;
      step     = '0;
      load     = 1'b0;
      load_val = '0;
      #1;
      lit("reset", RST_VAL, 0);
      #11 rst_n = 1'b1;
      run = 1;

`ifdef COUNTER_PRESCALE_EN
      cyc(0, 1, 0, 1, 1, 0);
      for (int i = 0; i < 8; i++) begin
         cyc(1, 1, 0, 1, 0, 0);
         lit("pre_run", (i + 1) / 4, (i % 4 == 3) ? 0 : 0);
      end
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(0, 1, 0, 1, 0, 0);
      cyc(0, 1, 0, 1, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      lit("pre_gap_hold", 2, 0);
      cyc(1, 1, 0, 1, 0, 0);
      lit("pre_gap_adv", 3, 0);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(0, 1, 0, 1, 1, 0);
      lit("pre_load", 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 0, 0);
      lit("pre_restart_hold", 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      lit("pre_restart_adv", 1, 0);
      cyc(0, 1, 0, 1, 1, 9);
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 0, 0);
      lit("pre_wrap", 0, 1);
`else
      cyc(0, 1, 0, 0, 1, 7);
      lit("load7", 7, 0);
      async_reset();
      cyc(0, 1, 0, 0, 1, 8);
      lit("load8", 8, 0);
      cyc(1, 1, 0, 3, 0, 0);
      lit("wrap_up", 1, 1);
      cyc(1, 1, 0, 3, 0, 0);
      lit("wrap_up_next", 4, 0);
      cyc(0, 1, 0, 0, 1, 1);
      cyc(1, 0, 0, 3, 0, 0);
      lit("wrap_down", 8, 1);
      cyc(0, 1, 0, 0, 1, 1);
      cyc(1, 0, 1, 3, 0, 0);
      lit("sat_down", 0, 1);
      cyc(1, 0, 1, 3, 0, 0);
      lit("sat_down_again", 0, 1);
      cyc(1, 1, 0, 1, 1, 200);
      lit("load_clamp", 9, 0);
      cyc(1, 1, 0, 1, 1, 5);
      lit("load5", 5, 0);
      cyc(1, 1, 0, 0, 0, 0);
      lit("step0", 5, 0);
      cyc(0, 1, 0, 0, 1, 2);
      cyc(1, 1, 0, 250, 0, 0);
      lit("step_clamp", 1, 1);
      cyc(0, 1, 0, 0, 1, 9);
      cyc(1, 1, 1, 1, 0, 0);
      lit("sat_up_limit", 9, 1);
      cyc(0, 1, 1, 1, 0, 0);
      lit("hold", 9, 0);
`endif

      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 9) < 7,
             $urandom_range(0, 1),
             $urandom_range(0, 1),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                         : $urandom_range(0, 4),
             $urandom_range(0, 15) == 0,
             ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255)
                                         : $urandom_range(0, 12));
         if ($urandom_range(0, 299) == 0) async_reset();
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
